// File: rtl/fa4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fa4_pkg
//  Description : Shared definitions for the nibble-serial adder sequencer:
//                FSM state encodings and the datapath slice width.
//  Revision    : 1.0  initial release
// ============================================================================
package fa4_pkg;

    // Width of one adder slice; every operation is processed in slices of this size.
    localparam int NIBBLE_W = 4;

    // Encoding 2'd3 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : fa4_pkg
`default_nettype wire

// File: rtl/fa4_mbit.sv
`default_nettype none
// ============================================================================
//  Module      : fa4_mbit
//  Description : 4-bit combinational full adder, {co,s} = a + b + ci.
//  Ports       : a, b  - 4-bit addends
//                ci    - carry in
//                s     - 4-bit sum
//                co    - carry out
//  Revision    : 1.0  initial release
// ============================================================================
module fa4_mbit (
    output logic [3:0] s,
    output logic       co,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule : fa4_mbit
`default_nettype wire

// File: rtl/fa4_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fa4_serial_ctrl
//  Description : Computes {co,s} = a + b + ci for WIDTH-bit operands using a
//                single shared 4-bit adder, one nibble per clock, LSB first.
//  Ports       : clk   - rising-edge clock
//                rst   - asynchronous active-high reset
//                start - request, sampled in IDLE or DONE
//                a, b  - WIDTH-bit operands, captured on the accepting edge
//                ci    - carry in, captured on the accepting edge
//                busy  - high while the operation is in progress
//                done  - one-cycle pulse when s/co carry a new result
//                s     - registered sum, held until the next result
//                co    - registered carry out, held with s
//  Revision    : 1.0  initial release
// ============================================================================
module fa4_serial_ctrl
    import fa4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  w_last;

    logic [WIDTH-1:0]      r_a_sh;
    logic [WIDTH-1:0]      r_b_sh;
    logic [WIDTH-1:0]      r_r_sh;
    logic                  r_cy;
    logic [CNT_W-1:0]      r_cnt;

    logic [NIBBLE_W-1:0]   w_nib;
    logic                  w_co;
    logic [WIDTH+3:0]      w_cat;
    logic [WIDTH-1:0]      w_r_next;

    fa4_mbit u_fa4 (
        .s  (w_nib),
        .co (w_co),
        .a  (r_a_sh[NIBBLE_W-1:0]),
        .b  (r_b_sh[NIBBLE_W-1:0]),
        .ci (r_cy)
    );

    // New nibble enters at the top while the result shifts right; taking the
    // upper WIDTH bits of the concatenation also covers the WIDTH==4 case.
    assign w_cat    = {w_nib, r_r_sh};
    assign w_r_next = w_cat[WIDTH+3:NIBBLE_W];

    assign w_last = (r_cnt == CNT_W'(NIB - 1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Back-to-back requests are accepted straight from DONE.
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand/result shifters, ripple carry, step counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_r_sh <= '0;
            r_cy   <= 1'b0;
            r_cnt  <= '0;
            s      <= '0;
            co     <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_cy   <= ci;
            r_cnt  <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh <= r_a_sh >> NIBBLE_W;
            r_b_sh <= r_b_sh >> NIBBLE_W;
            r_r_sh <= w_r_next;
            r_cy   <= w_co;
            r_cnt  <= r_cnt + CNT_W'(1);
            // Outputs update only on the completing edge, never mid-operation.
            if (w_last) begin
                s  <= w_r_next;
                co <= w_co;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule : fa4_serial_ctrl
`default_nettype wire

// File: tb/tb_fa4_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fa4_serial_ctrl
//  Description : Self-checking bench for fa4_serial_ctrl (WIDTH=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fa4_serial_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        co;

    int checks   = 0;
    int failures = 0;
    logic overlap_seen = 1'b0;

    fa4_serial_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done && busy) overlap_seen = 1'b1;
    end

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vci;
        logic [15:0] exp_s;
        logic        exp_co;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issues one request and waits for done; lat counts negedges after the
    // accepting edge up to and including the done sample.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci,
                          output int lat, output int nbusy);
        @(negedge clk);
        a = ta; b = tb_v; ci = tci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vecs[7];
    int   lat;
    int   nbusy;
    int   cyc;
    int   last;
    logic [16:0] gold;
    logic [15:0] ra, rb;
    logic        rci;
    logic [15:0] bb_a[4];
    logic [15:0] bb_b[4];
    logic        bb_c[4];
    int   late_done;

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[5] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_s",    {16'b0, s},    32'd0);
        chk("reset_co",   {31'b0, co},   32'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vci, lat, nbusy);
            chk($sformatf("vec%0d_latency", i), lat, 5);
            chk($sformatf("vec%0d_busy_cycles", i), nbusy, 4);
            chk($sformatf("vec%0d_s", i), {16'b0, s}, {16'b0, vecs[i].exp_s});
            chk($sformatf("vec%0d_co", i), {31'b0, co}, {31'b0, vecs[i].exp_co});
        end

        // start during RUN is ignored; s holds previous result (ABCD+1111)
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hAAAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_s_held", {16'b0, s}, 32'h0000BCDE);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_done_seen", {31'b0, done}, 32'd1);
        chk("ignore_s", {16'b0, s}, 32'h00000002);
        chk("ignore_co", {31'b0, co}, 32'd0);

        // Reset mid-RUN during the second nibble
        @(negedge clk);
        a = 16'h7777; b = 16'h1111; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_s",    {16'b0, s},    32'd0);
        chk("midrst_co",   {31'b0, co},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        late_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) late_done++;
        end
        chk("midrst_no_done", late_done, 0);
        run_op(16'h0123, 16'h0456, 1'b1, lat, nbusy);
        chk("postrst_latency", lat, 5);
        chk("postrst_s", {16'b0, s}, 32'h0000057A);

        // Back-to-back with start held high
        bb_a[0] = 16'h1111; bb_b[0] = 16'h2222; bb_c[0] = 1'b0;
        bb_a[1] = 16'hF000; bb_b[1] = 16'h1000; bb_c[1] = 1'b1;
        bb_a[2] = 16'h00FF; bb_b[2] = 16'h0001; bb_c[2] = 1'b0;
        bb_a[3] = 16'h9999; bb_b[3] = 16'h6666; bb_c[3] = 1'b1;
        @(negedge clk);
        a = bb_a[0]; b = bb_b[0]; ci = bb_c[0]; start = 1'b1;
        cyc = 0; last = -1;
        for (int i = 0; i < 4; i++) begin
            lat = 0;
            do begin
                @(negedge clk);
                cyc++;
                lat++;
            end while (!done && lat < 20);
            gold = {1'b0, bb_a[i]} + {1'b0, bb_b[i]} + {16'b0, bb_c[i]};
            chk($sformatf("b2b%0d_result", i), {15'b0, co, s}, {15'b0, gold});
            if (i > 0) chk($sformatf("b2b%0d_period", i), cyc - last, 5);
            last = cyc;
            if (i < 3) begin
                a = bb_a[i+1]; b = bb_b[i+1]; ci = bb_c[i+1];
            end else begin
                start = 1'b0;
            end
        end

        // Random operations against golden sum
        for (int i = 0; i < 200; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rci = 1'($urandom);
            run_op(ra, rb, rci, lat, nbusy);
            gold = {1'b0, ra} + {1'b0, rb} + {16'b0, rci};
            chk($sformatf("rand%0d_result", i), {15'b0, co, s}, {15'b0, gold});
        end
        chk("done_busy_overlap", {31'b0, overlap_seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fa4_serial_ctrl
`default_nettype wire
